sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Parametrised next-generation rectangle animator and compositor for the 640x480 VGA pipeline. It owns N_SPR bouncing rectangles, updates their positions once per frame, resolves per-pixel priority into one RGB332 pixel, and reports inter-sprite collisions per frame. It sits between the VGA timing generator (pixel coordinates, blanking, animate pulse) and the VGA colour pins.

## Interface
- N_SPR, 4: number of sprites, 1..8.
- H_RES, 640: visible width in pixels.
- V_RES, 480: visible height in pixels.
- SIZE, 32: half-size of every sprite; box is centre ±SIZE.
- VEL, 1: step in pixels per frame on each axis; VEL < SIZE.
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_pix_stb  in  1  pixel strobe; one i_clk cycle wide.
- i_animate  in  1  end-of-frame marker; acts only when i_pix_stb=1.
- i_x  in  10  current pixel x.
- i_y  in  9  current pixel y.
- i_blank  in  1  1 = outside the visible area.
- i_en  in  N_SPR  per-sprite motion enable.
- i_color  in  8*N_SPR  RGB332 colour; sprite k uses bits [8k+7:8k].
- i_bg  in  8  background RGB332.
- o_rgb  out  8  composited pixel, registered.
- o_hit  out  N_SPR  sprites covering the pixel, aligned with o_rgb.
- o_collide  out  1  one-i_clk pulse at frame end if any overlap occurred.
- o_collide_mask  out  N_SPR  sprites involved in an overlap last frame, held until the next frame end.

## Operation
- Per sprite k: 12-bit unsigned centre x_k, y_k and direction bits dx_k (1 = right), dy_k (1 = down).
- Reset values: x_k = (k+1)*H_RES/(N_SPR+1), y_k = (k+1)*V_RES/(N_SPR+1), dx_k = 1, dy_k = 1 for even k and 0 for odd k.
- Update on i_animate & i_pix_stb, only when i_en[k] = 1: x_k ±= VEL according to dx_k, and likewise for y.
  - After the move, if x_k >= H_RES-1-SIZE, dx_k = 0. If x_k <= SIZE, dx_k = 1.
  - The y axis is handled the same way, using V_RES.
  - Disabled sprites hold their position and direction.
- Box bounds: x1 = x_k-SIZE, x2 = x_k+SIZE, y1 = y_k-SIZE, y2 = y_k+SIZE, in 12-bit arithmetic. The bounce rules guarantee no underflow.
- Hit test: hit[k] = (i_x > x1) & (i_x < x2) & (i_y > y1) & (i_y < y2). Comparisons are strict, so edge pixels are outside the box.
- Priority: the lowest index wins. The pixel is i_color of the lowest set hit bit; if no bit is set, it is i_bg. When i_blank = 1, o_rgb = 0x00 and o_hit = 0.
- Collision accumulator acc[N_SPR-1:0], updated on each i_pix_stb with i_blank = 0: if popcount(hit) >= 2, acc |= hit.
- Frame end (i_animate & i_pix_stb):
  - o_collide_mask <= acc | current contribution.
  - o_collide <= 1 if that value is non-zero.
  - acc <= 0.

## Timing
- o_rgb and o_hit are registered on i_pix_stb. Latency is one pixel strobe from i_x/i_y/i_blank.
- Outputs hold between strobes.
- Position updates take effect from the strobe after the animate strobe. The animate-strobe pixel itself is evaluated with the old positions.
- o_collide is high for exactly one i_clk cycle and low otherwise.
- Reset values: o_rgb = 0x00, o_hit = 0, o_collide = 0, o_collide_mask = 0, acc = 0. Positions and directions take their reset values.
- Asserting reset mid-frame clears everything immediately, without waiting for a clock edge. Operation resumes on the first i_pix_stb after release.
- With i_pix_stb low, no state changes except the o_collide pulse returning to 0.

## Test plan
- **Reset and colour.** Defaults; colours 0xE0, 0x1C, 0x03, 0xFF; bg 0x00. Drive pixel (128,96) -> one strobe later o_rgb = 0xE0, o_hit = 0001. Drive pixel (0,0) -> o_rgb = 0x00, o_hit = 0000.
- **Strict edges.** Drive pixel (96,96) -> background. Drive pixel (97,96) -> 0xE0. Drive pixel (159,96) -> 0xE0. Drive pixel (160,96) -> background.
- **Bounce.** i_en = 0001. After 479 animate strobes x_0 = 607 and dx_0 = 0. After the 480th, x_0 = 606. Sprites 1-3 are unchanged.
- **Priority and collision.** SIZE = 80, i_en = 0. Drive pixel (190,150) -> o_rgb = colour 0, o_hit = 0011. At the next frame end, o_collide pulses for 1 cycle and mask = 0011. The following frame has no overlap pixel -> mask = 0000 and no pulse.
- **Blanking.** i_blank = 1 at pixel (190,150) with SIZE = 80 -> o_rgb = 0x00, o_hit = 0. At frame end there is no pulse and mask = 0000.
- **Mid-frame reset.** Assert i_rst asynchronously after 1000 strobes with acc non-zero. All outputs read 0 before the next i_clk edge. Positions return to 128/96, 256/192, 384/288, 512/384.

Source files
------------

// File: rtl/sprite_compositor.sv
// Bouncing-rectangle animator and per-pixel compositor for a 640x480 VGA pipeline.
// Resolves lowest-index priority into RGB332 and reports per-frame sprite overlaps.
module sprite_compositor #(
  parameter int unsigned N_SPR = 4,
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480,
  parameter int unsigned SIZE  = 32,
  parameter int unsigned VEL   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_stb,
  input  logic               i_animate,
  input  logic [9:0]         i_x,
  input  logic [8:0]         i_y,
  input  logic               i_blank,
  input  logic [N_SPR-1:0]   i_en,
  input  logic [8*N_SPR-1:0] i_color,
  input  logic [7:0]         i_bg,
  output logic [7:0]         o_rgb,
  output logic [N_SPR-1:0]   o_hit,
  output logic               o_collide,
  output logic [N_SPR-1:0]   o_collide_mask
);

  localparam logic [11:0] Size = 12'(SIZE);
  localparam logic [11:0] Vel  = 12'(VEL);
  localparam logic [11:0] XMax = 12'(H_RES - 1 - SIZE);
  localparam logic [11:0] YMax = 12'(V_RES - 1 - SIZE);

  logic [11:0]      x_q [N_SPR];
  logic [11:0]      y_q [N_SPR];
  logic [11:0]      x_d [N_SPR];
  logic [11:0]      y_d [N_SPR];
  logic [N_SPR-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [N_SPR-1:0] acc_q, acc_d;
  logic [N_SPR-1:0] hit_q, hit_d;
  logic [N_SPR-1:0] mask_q, mask_d;
  logic [7:0]       rgb_q, rgb_d;
  logic             collide_q, collide_d;

  logic [N_SPR-1:0] hit;
  logic [N_SPR-1:0] contrib;
  logic [N_SPR-1:0] frame_mask;
  logic [3:0]       hit_cnt;
  logic [7:0]       pix_rgb;
  logic             frame_end;
  logic [11:0]      px, py;

  assign px        = {2'b00, i_x};
  assign py        = {3'b000, i_y};
  assign frame_end = i_pix_stb & i_animate;

  // Hit test and priority use the positions in effect for this strobe.
  always_comb begin
    hit     = '0;
    hit_cnt = '0;
    pix_rgb = i_bg;
    for (int k = 0; k < int'(N_SPR); k++) begin
      hit[k] = (px > (x_q[k] - Size)) && (px < (x_q[k] + Size)) &&
               (py > (y_q[k] - Size)) && (py < (y_q[k] + Size));
      hit_cnt = hit_cnt + 4'(hit[k]);
    end
    for (int k = int'(N_SPR) - 1; k >= 0; k--) begin
      if (hit[k]) pix_rgb = i_color[8*k +: 8];
    end
  end

  assign contrib    = (!i_blank && (hit_cnt >= 4'd2)) ? hit : '0;
  assign frame_mask = acc_q | contrib;

  always_comb begin
    rgb_d     = rgb_q;
    hit_d     = hit_q;
    acc_d     = acc_q;
    mask_d    = mask_q;
    collide_d = 1'b0;
    dx_d      = dx_q;
    dy_d      = dy_q;
    for (int k = 0; k < int'(N_SPR); k++) begin
      x_d[k] = x_q[k];
      y_d[k] = y_q[k];
    end

    if (i_pix_stb) begin
      rgb_d = i_blank ? 8'h00 : pix_rgb;
      hit_d = i_blank ? '0 : hit;
      acc_d = frame_mask;
    end

    if (frame_end) begin
      mask_d    = frame_mask;
      collide_d = |frame_mask;
      acc_d     = '0;
      for (int k = 0; k < int'(N_SPR); k++) begin
        if (i_en[k]) begin
          x_d[k] = dx_q[k] ? x_q[k] + Vel : x_q[k] - Vel;
          y_d[k] = dy_q[k] ? y_q[k] + Vel : y_q[k] - Vel;
          if (x_d[k] >= XMax) dx_d[k] = 1'b0;
          if (x_d[k] <= Size) dx_d[k] = 1'b1;
          if (y_d[k] >= YMax) dy_d[k] = 1'b0;
          if (y_d[k] <= Size) dy_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rgb_q     <= 8'h00;
      hit_q     <= '0;
      acc_q     <= '0;
      mask_q    <= '0;
      collide_q <= 1'b0;
      for (int k = 0; k < int'(N_SPR); k++) begin
        x_q[k]  <= 12'((k + 1) * int'(H_RES) / (int'(N_SPR) + 1));
        y_q[k]  <= 12'((k + 1) * int'(V_RES) / (int'(N_SPR) + 1));
        dx_q[k] <= 1'b1;
        dy_q[k] <= ((k % 2) == 0);
      end
    end else begin
      rgb_q     <= rgb_d;
      hit_q     <= hit_d;
      acc_q     <= acc_d;
      mask_q    <= mask_d;
      collide_q <= collide_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      for (int k = 0; k < int'(N_SPR); k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
      end
    end
  end

  assign o_rgb          = rgb_q;
  assign o_hit          = hit_q;
  assign o_collide      = collide_q;
  assign o_collide_mask = mask_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: one SIZE=32 instance (a) for colour, edges and
// bounce, one SIZE=80 instance (b) for priority, collisions and blanking; shared stimulus.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, anim, blank;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [31:0] color;
  logic [7:0]  bg;
  logic [3:0]  en_a, en_b;
  logic [7:0]  rgb_a, rgb_b;
  logic [3:0]  hit_a, hit_b, mask_a, mask_b;
  logic        col_a, col_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sprite_compositor #(.N_SPR(4), .H_RES(640), .V_RES(480), .SIZE(32), .VEL(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_animate(anim), .i_x(x), .i_y(y),
    .i_blank(blank), .i_en(en_a), .i_color(color), .i_bg(bg), .o_rgb(rgb_a),
    .o_hit(hit_a), .o_collide(col_a), .o_collide_mask(mask_a)
  );

  sprite_compositor #(.N_SPR(4), .H_RES(640), .V_RES(480), .SIZE(80), .VEL(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_animate(anim), .i_x(x), .i_y(y),
    .i_blank(blank), .i_en(en_b), .i_color(color), .i_bg(bg), .o_rgb(rgb_b),
    .o_hit(hit_b), .o_collide(col_b), .o_collide_mask(mask_b)
  );

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic       bl;
    logic [7:0] bg;
    logic [7:0] rgb;
    logic [3:0] hit;
  } vec_t;

  vec_t tv[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One strobed pixel; returns at the falling edge after the registering edge.
  task automatic pix(input logic [9:0] px, input logic [8:0] py, input logic bl,
                     input logic an);
    @(negedge clk);
    x = px; y = py; blank = bl; anim = an; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0; anim = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; anim = 1'b0; blank = 1'b0; x = '0; y = '0;
    color = {8'hFF, 8'h03, 8'h1C, 8'hE0}; bg = 8'h00; en_a = 4'h0; en_b = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset rgb", 32'(rgb_a), 32'h00);
    check("reset hit", 32'(hit_a), 32'h0);
    check("reset collide", 32'(col_a), 32'h0);
    check("reset mask", 32'(mask_b), 32'h0);

    tv[0]  = '{10'd128, 9'd96,  1'b0, 8'h00, 8'hE0, 4'b0001};
    tv[1]  = '{10'd0,   9'd0,   1'b0, 8'h00, 8'h00, 4'b0000};
    tv[2]  = '{10'd96,  9'd96,  1'b0, 8'h00, 8'h00, 4'b0000};
    tv[3]  = '{10'd97,  9'd96,  1'b0, 8'h00, 8'hE0, 4'b0001};
    tv[4]  = '{10'd159, 9'd96,  1'b0, 8'h00, 8'hE0, 4'b0001};
    tv[5]  = '{10'd160, 9'd96,  1'b0, 8'h00, 8'h00, 4'b0000};
    tv[6]  = '{10'd0,   9'd0,   1'b0, 8'h49, 8'h49, 4'b0000};
    tv[7]  = '{10'd128, 9'd96,  1'b1, 8'h49, 8'h00, 4'b0000};
    tv[8]  = '{10'd256, 9'd192, 1'b0, 8'h49, 8'h1C, 4'b0010};
    tv[9]  = '{10'd384, 9'd288, 1'b0, 8'h49, 8'h03, 4'b0100};
    tv[10] = '{10'd512, 9'd384, 1'b0, 8'h49, 8'hFF, 4'b1000};

    for (int i = 0; i < 11; i++) begin
      bg = tv[i].bg;
      pix(tv[i].x, tv[i].y, tv[i].bl, 1'b0);
      check($sformatf("vec%0d rgb", i), 32'(rgb_a), 32'(tv[i].rgb));
      check($sformatf("vec%0d hit", i), 32'(hit_a), 32'(tv[i].hit));
    end

    // Outputs hold while the strobe is low.
    x = 10'd0; y = 9'd0;
    repeat (3) @(negedge clk);
    check("hold rgb", 32'(rgb_a), 32'hFF);
    check("hold hit", 32'(hit_a), 32'h8);

    bg = 8'h00;
    pix(10'd0, 9'd0, 1'b0, 1'b1);
    pix(10'd190, 9'd150, 1'b0, 1'b0);
    check("prio rgb", 32'(rgb_b), 32'hE0);
    check("prio hit", 32'(hit_b), 32'h3);
    // Animate without a strobe must not end the frame.
    @(negedge clk); anim = 1'b1;
    repeat (2) @(negedge clk);
    check("anim no stb collide", 32'(col_b), 32'h0);
    check("anim no stb mask", 32'(mask_b), 32'h0);
    anim = 1'b0;
    pix(10'd0, 9'd0, 1'b0, 1'b1);
    check("frame1 collide", 32'(col_b), 32'h1);
    check("frame1 mask", 32'(mask_b), 32'h3);
    @(negedge clk);
    check("frame1 pulse width", 32'(col_b), 32'h0);
    check("frame1 mask held", 32'(mask_b), 32'h3);

    pix(10'd0, 9'd0, 1'b0, 1'b0);
    pix(10'd0, 9'd0, 1'b0, 1'b1);
    check("frame2 collide", 32'(col_b), 32'h0);
    check("frame2 mask", 32'(mask_b), 32'h0);

    // Overlap on the animate strobe itself still counts for that frame.
    pix(10'd190, 9'd150, 1'b0, 1'b1);
    check("frame3 collide", 32'(col_b), 32'h1);
    check("frame3 mask", 32'(mask_b), 32'h3);
    pix(10'd0, 9'd0, 1'b0, 1'b1);
    check("frame4 mask", 32'(mask_b), 32'h0);

    pix(10'd190, 9'd150, 1'b1, 1'b0);
    check("blank rgb", 32'(rgb_b), 32'h00);
    check("blank hit", 32'(hit_b), 32'h0);
    pix(10'd0, 9'd0, 1'b0, 1'b1);
    check("blank collide", 32'(col_b), 32'h0);
    check("blank mask", 32'(mask_b), 32'h0);

    // Bounce: sprite 0 reaches x=607 after 479 moves, y=319 after bouncing at 447.
    en_a = 4'b0001;
    for (int i = 0; i < 479; i++) pix(10'd0, 9'd0, 1'b0, 1'b1);
    pix(10'd638, 9'd319, 1'b0, 1'b0);
    check("b479 right in", 32'(hit_a), 32'h1);
    pix(10'd576, 9'd319, 1'b0, 1'b0);
    check("b479 left in", 32'(hit_a), 32'h1);
    pix(10'd575, 9'd319, 1'b0, 1'b0);
    check("b479 left edge", 32'(hit_a), 32'h0);
    pix(10'd0, 9'd0, 1'b0, 1'b1);
    pix(10'd638, 9'd319, 1'b0, 1'b0);
    check("b480 right edge", 32'(hit_a), 32'h0);
    pix(10'd575, 9'd319, 1'b0, 1'b0);
    check("b480 left in", 32'(hit_a), 32'h1);
    pix(10'd225, 9'd192, 1'b0, 1'b0);
    check("spr1 still in", 32'(hit_a), 32'h2);
    pix(10'd224, 9'd192, 1'b0, 1'b0);
    check("spr1 edge", 32'(hit_a), 32'h0);

    // Mid-frame reset with a live accumulator.
    en_a = 4'b1111;
    for (int i = 0; i < 1000; i++) pix(10'd190, 9'd150, 1'b0, (i % 200) == 100);
    check("pre-reset mask", 32'(mask_b), 32'h3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rgb a", 32'(rgb_a), 32'h00);
    check("async hit a", 32'(hit_a), 32'h0);
    check("async rgb b", 32'(rgb_b), 32'h00);
    check("async hit b", 32'(hit_b), 32'h0);
    check("async mask b", 32'(mask_b), 32'h0);
    check("async collide b", 32'(col_b), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    en_a = 4'b0000;
    pix(10'd128, 9'd96, 1'b0, 1'b0);
    check("rst pos0", 32'(hit_a), 32'h1);
    pix(10'd97, 9'd96, 1'b0, 1'b0);
    check("rst pos0 edge in", 32'(hit_a), 32'h1);
    pix(10'd96, 9'd96, 1'b0, 1'b0);
    check("rst pos0 edge out", 32'(hit_a), 32'h0);
    pix(10'd256, 9'd192, 1'b0, 1'b0);
    check("rst pos1", 32'(hit_a), 32'h2);
    pix(10'd384, 9'd288, 1'b0, 1'b0);
    check("rst pos2", 32'(hit_a), 32'h4);
    pix(10'd512, 9'd384, 1'b0, 1'b0);
    check("rst pos3", 32'(hit_a), 32'h8);
    pix(10'd0, 9'd0, 1'b0, 1'b1);
    check("rst acc collide", 32'(col_b), 32'h0);
    check("rst acc mask", 32'(mask_b), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
